camera_word_packer: RTL and testbench



---
 rtl/camera_pkg.sv | 27 ++
 rtl/packer_word_buffer.sv | 69 ++++++
 rtl/camera_word_packer.sv | 166 ++++++++++++++++
 tb/tb_camera_word_packer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared types and constants for the camera pixel-to-word packer.
package camera_pkg;

    localparam int DEFAULT_H_ACTIVE = 1280;
    localparam int DEFAULT_V_ACTIVE = 720;
    localparam int PIX_PER_WORD     = 8;
    localparam int PIX_W            = 16;
    localparam int WORD_W           = 128;

    typedef enum logic [1:0] {
        SYNC,
        PACK,
        DROP
    } packer_state_t;

    // One buffered output beat: the packed word plus its end-of-frame flag.
    typedef struct packed {
        logic              tlast;
        logic [WORD_W-1:0] data;
    } buf_entry_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/packer_word_buffer.sv
// Small synchronous FIFO holding completed {tlast, data} words until the
// downstream AXI-Stream sink accepts them. A push is honoured when full if a
// pop happens in the same cycle. DEPTH must be a power of two.
module packer_word_buffer
    import camera_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  buf_entry_t push_entry,
    input  logic       pop,
    output buf_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int              PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]  FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    buf_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   level;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LEVEL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // An empty buffer presents all-zero data so the outputs are clean after reset.
    assign head = empty ? '0 : mem[rd_ptr];

    // Entry storage: written on push only.
    // NOTE: the storage array has no reset; stale entries are never visible
    // because head is forced to zero while empty, and this keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Read/write pointers and fill level.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/camera_word_packer.sv
// Packs a non-stallable 16-bit camera pixel stream into 128-bit AXI-Stream
// words (pixel 0 in bits [15:0]), flags the last word of each frame with
// tlast, and drops the remainder of a frame cleanly when the output buffer
// overflows. Optional test-pattern source: define CAMERA_PACKER_TPG_EN to add
// the tpg_enable port, which replaces pixel data with the in-frame pixel index.
module camera_word_packer
    import camera_pkg::*;
#(
    parameter int H_ACTIVE  = DEFAULT_H_ACTIVE,
    parameter int V_ACTIVE  = DEFAULT_V_ACTIVE,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_valid,
    input  logic [PIX_W-1:0]  cam_pixel,
    input  logic              cam_frame_start,
    output logic [WORD_W-1:0] m_axis_data,
    output logic              m_axis_valid,
    output logic              m_axis_tlast,
    input  logic              m_axis_ready,
    output logic [15:0]       overflow_count,
    output logic [15:0]       short_frame_count
`ifdef CAMERA_PACKER_TPG_EN
    ,
    input  logic              tpg_enable
`endif
);

    localparam int WORDS_PER_FRAME = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;
    localparam int WC_W            = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_FRAME - 1);

    packer_state_t     state;
    packer_state_t     state_next;
    logic [2:0]        lane;
    logic [2:0]        lane_next;
    logic [WC_W-1:0]   word_cnt;
    logic [WC_W-1:0]   word_cnt_next;
    logic [WORD_W-1:0] pack_reg;
    logic [WORD_W-1:0] pack_next;
    logic [WORD_W-1:0] word_fill;
    logic [PIX_W-1:0]  pix;
    logic              restart;
    logic              tlast_now;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              ovf_inc;
    logic              short_inc;
    buf_entry_t        push_entry;
    buf_entry_t        head;

    // A frame start restarts packing unless it lands exactly where a new
    // frame was expected anyway (PACK, lane 0, word 0).
    assign restart = cam_valid && cam_frame_start &&
                     ((state != PACK) || (lane != 3'd0) || (word_cnt != '0));

`ifdef CAMERA_PACKER_TPG_EN
    logic [PIX_W-1:0] pix_idx;
    assign pix_idx = restart ? '0 : PIX_W'({word_cnt, lane});
    assign pix     = tpg_enable ? pix_idx : cam_pixel;
`else
    assign pix = cam_pixel;
`endif

    assign pop          = m_axis_valid && m_axis_ready;
    assign tlast_now    = (word_cnt == LAST_WORD);
    assign push_entry   = '{tlast: tlast_now, data: word_fill};
    assign m_axis_valid = !empty;
    assign m_axis_data  = head.data;
    assign m_axis_tlast = head.tlast;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, packing datapath and buffer push decisions.
    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next    = state;
        lane_next     = lane;
        word_cnt_next = word_cnt;
        pack_next     = pack_reg;
        push          = 1'b0;
        ovf_inc       = 1'b0;
        short_inc     = 1'b0;
        word_fill     = pack_reg;
        word_fill[{lane, 4'b0000} +: PIX_W] = pix;

        if (cam_valid) begin
            if (restart) begin
                // First pixel of a (re)started frame: lane 0 of word 0.
                short_inc        = (state == PACK);
                pack_next[PIX_W-1:0] = pix;
                lane_next        = 3'd1;
                word_cnt_next    = '0;
                state_next       = PACK;
            end else if (state == PACK) begin
                pack_next = word_fill;
                lane_next = lane + 3'd1;
                if (lane == 3'd7) begin
                    if (full && !pop) begin
                        // No room: lose this word and the rest of the frame.
                        ovf_inc       = 1'b1;
                        lane_next     = 3'd0;
                        word_cnt_next = '0;
                        state_next    = DROP;
                    end else begin
                        push          = 1'b1;
                        word_cnt_next = tlast_now ? '0 : word_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Packing register, lane index and word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane     <= '0;
            word_cnt <= '0;
            pack_reg <= '0;
        end else begin
            lane     <= lane_next;
            word_cnt <= word_cnt_next;
            pack_reg <= pack_next;
        end
    end

    // Saturating error counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_count    <= '0;
            short_frame_count <= '0;
        end else begin
            if (ovf_inc) begin
                overflow_count <= sat_inc16(overflow_count);
            end
            if (short_inc) begin
                short_frame_count <= sat_inc16(short_frame_count);
            end
        end
    end

    packer_word_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty)
    );

endmodule

// File: tb/tb_camera_word_packer.sv
// Directed bench for camera_word_packer using a reduced 16x4 frame
// (64 pixels, 8 words per frame) so whole frames fit in a short run.
module tb_camera_word_packer;

    localparam int H_ACT = 16;
    localparam int V_ACT = 4;
    localparam int PPF   = H_ACT * V_ACT;
    localparam int WPF   = PPF / 8;

    logic         clk;
    logic         rst;
    logic         cam_valid;
    logic [15:0]  cam_pixel;
    logic         cam_frame_start;
    logic [127:0] m_axis_data;
    logic         m_axis_valid;
    logic         m_axis_tlast;
    logic         m_axis_ready;
    logic [15:0]  overflow_count;
    logic [15:0]  short_frame_count;
`ifdef CAMERA_PACKER_TPG_EN
    logic         tpg_enable = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic [128:0] out_q[$];

    camera_word_packer #(
        .H_ACTIVE  (H_ACT),
        .V_ACTIVE  (V_ACT),
        .BUF_DEPTH (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cam_valid         (cam_valid),
        .cam_pixel         (cam_pixel),
        .cam_frame_start   (cam_frame_start),
        .m_axis_data       (m_axis_data),
        .m_axis_valid      (m_axis_valid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_ready      (m_axis_ready),
        .overflow_count    (overflow_count),
        .short_frame_count (short_frame_count)
`ifdef CAMERA_PACKER_TPG_EN
        ,
        .tpg_enable        (tpg_enable)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted beat midway between clock edges.
    always @(negedge clk) begin
        if (m_axis_valid && m_axis_ready) begin
            out_q.push_back({m_axis_tlast, m_axis_data});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected word built from eight consecutive pixel values base..base+7.
    function automatic logic [127:0] exp_word(input int base);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            w[16*k +: 16] = 16'(base + k);
        end
        return w;
    endfunction

    // One camera cycle: inputs change 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [15:0] pix, input logic fs);
        @(posedge clk);
        #1;
        cam_valid       = v;
        cam_pixel       = pix;
        cam_frame_start = fs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 16'h0000, 1'b0);
        end
    endtask

    task automatic do_reset(input logic rdy);
        rst             = 1'b1;
        cam_valid       = 1'b0;
        cam_pixel       = 16'h0000;
        cam_frame_start = 1'b0;
        m_axis_ready    = rdy;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_q.delete();
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++;
        if (m_axis_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", m_axis_valid);
        end
        checks++;
        if (m_axis_data !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", m_axis_data);
        end
        checks++;
        if (m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_tlast: got %b want 0", m_axis_tlast);
        end
        checks++;
        if (overflow_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_overflow_count: got %h want 0", overflow_count);
        end
        checks++;
        if (short_frame_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_short_count: got %h want 0", short_frame_count);
        end
    endtask

    task automatic test_single_word();
        do_reset(1'b1);
        drive(1'b1, 16'h0000, 1'b1);
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 16'(i), 1'b0);
        end
        checks++;
        if (m_axis_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid: got %b want 0", m_axis_valid);
        end
        drive(1'b0, 16'h0000, 1'b0);
        checks++;
        if (m_axis_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency_valid: got %b want 1", m_axis_valid);
        end
        checks++;
        if (m_axis_data !== 128'h0007_0006_0005_0004_0003_0002_0001_0000) begin
            errors++;
            $display("FAIL single_data: got %h want %h", m_axis_data,
                     128'h0007_0006_0005_0004_0003_0002_0001_0000);
        end
        checks++;
        if (m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL single_tlast: got %b want 0", m_axis_tlast);
        end
        idle(2);
        checks++;
        if (out_q.size() !== 1) begin
            errors++;
            $display("FAIL single_count: got %0d want 1", out_q.size());
        end
    endtask

    // Two frames back to back; the second carries no frame_start marker.
    task automatic test_full_frame();
        do_reset(1'b1);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < PPF; i++) begin
                drive(1'b1, 16'(i), (f == 0 && i == 0) ? 1'b1 : 1'b0);
            end
        end
        idle(3);
        checks++;
        if (out_q.size() !== 2 * WPF) begin
            errors++;
            $display("FAIL frame_word_count: got %0d want %0d", out_q.size(), 2 * WPF);
        end
        for (int w = 0; w < 2 * WPF; w++) begin
            checks++;
            if (out_q[w][127:0] !== exp_word((w % WPF) * 8)) begin
                errors++;
                $display("FAIL frame_data[%0d]: got %h want %h", w, out_q[w][127:0],
                         exp_word((w % WPF) * 8));
            end
            checks++;
            if (out_q[w][128] !== ((w == WPF - 1) || (w == 2 * WPF - 1))) begin
                errors++;
                $display("FAIL frame_tlast[%0d]: got %b want %b", w, out_q[w][128],
                         ((w == WPF - 1) || (w == 2 * WPF - 1)));
            end
        end
        checks++;
        if (short_frame_count !== 16'h0 || overflow_count !== 16'h0) begin
            errors++;
            $display("FAIL frame_counters: got short=%h ovf=%h want 0/0",
                     short_frame_count, overflow_count);
        end
    endtask

    task automatic test_overflow();
        do_reset(1'b1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 16'(i), (i == 0) ? 1'b1 : 1'b0);
        end
        idle(2);
        m_axis_ready = 1'b0;
        for (int i = 16; i < PPF; i++) begin
            drive(1'b1, 16'(i), 1'b0);
        end
        idle(1);
        checks++;
        if (overflow_count !== 16'd1) begin
            errors++;
            $display("FAIL ovf_count: got %0d want 1", overflow_count);
        end
        checks++;
        if (out_q.size() !== 2) begin
            errors++;
            $display("FAIL ovf_emitted_before_ready: got %0d want 2", out_q.size());
        end
        checks++;
        if (m_axis_data !== exp_word(16)) begin
            errors++;
            $display("FAIL ovf_head: got %h want %h", m_axis_data, exp_word(16));
        end
        drive(1'b1, 16'h0000, 1'b1);
        m_axis_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 16'(i), 1'b0);
        end
        idle(4);
        checks++;
        if (out_q.size() !== 5) begin
            errors++;
            $display("FAIL ovf_total_words: got %0d want 5", out_q.size());
        end
        for (int w = 0; w < 5; w++) begin
            checks++;
            if (out_q[w] !== {1'b0, exp_word((w < 4) ? w * 8 : 0)}) begin
                errors++;
                $display("FAIL ovf_word[%0d]: got %h want %h", w, out_q[w],
                         {1'b0, exp_word((w < 4) ? w * 8 : 0)});
            end
        end
        checks++;
        if (overflow_count !== 16'd1 || short_frame_count !== 16'd0) begin
            errors++;
            $display("FAIL ovf_final_counters: got ovf=%0d short=%0d want 1/0",
                     overflow_count, short_frame_count);
        end
    endtask

    task automatic test_short_frame();
        do_reset(1'b1);
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 16'(16'h0100 + i), (i == 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < PPF; i++) begin
            drive(1'b1, 16'(i), (i == 0) ? 1'b1 : 1'b0);
        end
        idle(3);
        checks++;
        if (short_frame_count !== 16'd1) begin
            errors++;
            $display("FAIL short_count: got %0d want 1", short_frame_count);
        end
        checks++;
        if (out_q.size() !== 1 + WPF) begin
            errors++;
            $display("FAIL short_words: got %0d want %0d", out_q.size(), 1 + WPF);
        end
        checks++;
        if (out_q[0] !== {1'b0, exp_word(16'h0100)}) begin
            errors++;
            $display("FAIL short_old_word: got %h want %h", out_q[0], {1'b0, exp_word(16'h0100)});
        end
        for (int w = 1; w <= WPF; w++) begin
            checks++;
            if (out_q[w] !== {(w == WPF) ? 1'b1 : 1'b0, exp_word((w - 1) * 8)}) begin
                errors++;
                $display("FAIL short_new_word[%0d]: got %h want %h", w, out_q[w],
                         {(w == WPF) ? 1'b1 : 1'b0, exp_word((w - 1) * 8)});
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 16'(i), (i == 0) ? 1'b1 : 1'b0);
        end
        checks++;
        if (m_axis_data !== exp_word(0)) begin
            errors++;
            $display("FAIL b2b_hold_a: got %h want %h", m_axis_data, exp_word(0));
        end
        for (int i = 17; i < 23; i++) begin
            drive(1'b1, 16'(i), 1'b0);
        end
        checks++;
        if (m_axis_data !== exp_word(0) || m_axis_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold_b: got valid=%b data=%h want 1/%h",
                     m_axis_valid, m_axis_data, exp_word(0));
        end
        checks++;
        if (out_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_no_pop_yet: got %0d want 0", out_q.size());
        end
        drive(1'b1, 16'd23, 1'b0);
        m_axis_ready = 1'b1;
        for (int i = 24; i < 32; i++) begin
            drive(1'b1, 16'(i), 1'b0);
        end
        idle(5);
        checks++;
        if (overflow_count !== 16'd0) begin
            errors++;
            $display("FAIL b2b_overflow: got %0d want 0", overflow_count);
        end
        checks++;
        if (out_q.size() !== 4) begin
            errors++;
            $display("FAIL b2b_words: got %0d want 4", out_q.size());
        end
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (out_q[w] !== {1'b0, exp_word(w * 8)}) begin
                errors++;
                $display("FAIL b2b_word[%0d]: got %h want %h", w, out_q[w], {1'b0, exp_word(w * 8)});
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        drive(1'b1, 16'h0050, 1'b1);
        drive(1'b1, 16'h0051, 1'b0);
        drive(1'b1, 16'h0052, 1'b0);
        drive(1'b1, 16'h0060, 1'b1);
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 16'(16'h0060 + i), 1'b0);
        end
        drive(1'b1, 16'h0070, 1'b0);
        drive(1'b1, 16'h0071, 1'b0);
        drive(1'b1, 16'h0072, 1'b0);
        checks++;
        if (short_frame_count !== 16'd1 || m_axis_valid !== 1'b1) begin
            errors++;
            $display("FAIL arst_precondition: got short=%0d valid=%b want 1/1",
                     short_frame_count, m_axis_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m_axis_valid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL arst_valid_tlast: got %b/%b want 0/0", m_axis_valid, m_axis_tlast);
        end
        checks++;
        if (m_axis_data !== 128'h0) begin
            errors++;
            $display("FAIL arst_data: got %h want 0", m_axis_data);
        end
        checks++;
        if (short_frame_count !== 16'd0) begin
            errors++;
            $display("FAIL arst_short_count: got %0d want 0", short_frame_count);
        end
        @(posedge clk);
        #1;
        rst          = 1'b0;
        cam_valid    = 1'b0;
        m_axis_ready = 1'b1;
        out_q.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(16'h0090 + i), 1'b0);
        end
        idle(3);
        checks++;
        if (out_q.size() !== 0) begin
            errors++;
            $display("FAIL arst_ignore_presync: got %0d words want 0", out_q.size());
        end
        drive(1'b1, 16'h0000, 1'b1);
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 16'(i), 1'b0);
        end
        idle(3);
        checks++;
        if (out_q.size() !== 1 || out_q[0] !== {1'b0, exp_word(0)}) begin
            errors++;
            $display("FAIL arst_resume: got %0d words first=%h want 1/%h",
                     out_q.size(), out_q[0], {1'b0, exp_word(0)});
        end
    endtask

    initial begin
        rst             = 1'b1;
        cam_valid       = 1'b0;
        cam_pixel       = 16'h0000;
        cam_frame_start = 1'b0;
        m_axis_ready    = 1'b0;
        test_reset();
        test_single_word();
        test_full_frame();
        test_overflow();
        test_short_frame();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
